// File: rtl/quad_enc_bank_pkg.sv
// Shared types and helpers for the quadrature encoder bank: snapshot states,
// quadrature state encodings and the transition decoder.
package rap_enc_pkg;

  typedef enum logic [0:0] {
    SNAP_IDLE   = 1'b0,
    SNAP_STREAM = 1'b1
  } snap_state_e;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_FWD     = 2'd1,
    DIR_REV     = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_e;

  // Quadrature states are encoded as {A,B}
  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  function automatic dir_e quad_dir(input logic [1:0] prev, input logic [1:0] cur);
    dir_e dir;
    dir = DIR_NONE;
    case ({prev, cur})
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: dir = DIR_FWD;
      {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: dir = DIR_REV;
      {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: dir = DIR_ILLEGAL;
      default:                                        dir = DIR_NONE;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/quad_enc_bank_if.sv
// Snapshot stream interface: one beat per channel, valid/ready handshake.
interface quad_enc_bank_if #(
  parameter int CH_W     = 2,
  parameter int ENC_BITS = 32
);
  logic                       out_valid;
  logic                       out_ready;
  logic [CH_W-1:0]            out_channel;
  logic signed [ENC_BITS-1:0] out_count;
  logic                       out_fault;

  modport master (output out_valid, out_channel, out_count, out_fault, input out_ready);
  modport slave  (input out_valid, out_channel, out_count, out_fault, output out_ready);
endinterface

// File: rtl/quad_enc_bank_channel.sv
// One encoder channel: pin synchroniser, quadrature decode, wrapping signed
// counter with per-step multiplier, and sticky illegal-transition fault.
module quad_enc_channel
  import rap_enc_pkg::*;
#(
  parameter int ENC_BITS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enc_a_i,
  input  logic                enc_b_i,
  input  logic [7:0]          mult_i,
  input  logic                count_clear_i,
  input  logic                fault_clear_i,
  output logic [ENC_BITS-1:0] count_o,
  output logic                fault_o
);

  logic [SYNC_STAGES-1:0] sync_a_q;
  logic [SYNC_STAGES-1:0] sync_b_q;
  logic [1:0]             prev_q;
  logic [1:0]             cur_s;
  logic [ENC_BITS-1:0]    count_q, count_d;
  logic [ENC_BITS-1:0]    step_s;
  logic                   fault_q, fault_d;
  dir_e                   dir_s;

  assign cur_s  = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
  assign step_s = ENC_BITS'(mult_i);
  assign dir_s  = quad_dir(prev_q, cur_s);

  // Clears take priority over any same-cycle step or fault
  always_comb begin
    count_d = count_q;
    fault_d = fault_q;
    if (count_clear_i) begin
      count_d = {ENC_BITS{1'b0}};
    end else if (dir_s == DIR_FWD) begin
      count_d = count_q + step_s;
    end else if (dir_s == DIR_REV) begin
      count_d = count_q - step_s;
    end else begin
      count_d = count_q;
    end
    if (fault_clear_i) begin
      fault_d = 1'b0;
    end else if (dir_s == DIR_ILLEGAL) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  // Synchroniser, previous-state and counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_a_q <= {SYNC_STAGES{1'b0}};
      sync_b_q <= {SYNC_STAGES{1'b0}};
      prev_q   <= 2'b00;
      count_q  <= {ENC_BITS{1'b0}};
      fault_q  <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], enc_a_i};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], enc_b_i};
      prev_q   <= cur_s;
      count_q  <= count_d;
      fault_q  <= fault_d;
    end
  end

  assign count_o = count_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/quad_enc_bank.sv
// Bank of CHANNELS quadrature counters with an atomic all-channel snapshot
// streamed out one channel per beat.
module quad_enc_bank
  import rap_enc_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int ENC_BITS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   ENC_A,
  input  logic [CHANNELS-1:0]   ENC_B,
  input  logic [8*CHANNELS-1:0] multiplier,
  input  logic [CHANNELS-1:0]   count_clear,
  input  logic [CHANNELS-1:0]   fault_clear,
  output logic [CHANNELS-1:0]   faultn,
  input  logic                  snap_req,
  output logic                  snap_busy,
  output logic                  snap_done,
  quad_enc_bank_if.master       out_if
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0][ENC_BITS-1:0] live_count_s;
  logic [CHANNELS-1:0]               live_fault_s;
  logic [CHANNELS-1:0][ENC_BITS-1:0] shadow_count_q;
  logic [CHANNELS-1:0]               shadow_fault_q;

  snap_state_e         state_q, state_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [CH_W-1:0]     next_chan_s;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [ENC_BITS-1:0] out_count_q, out_count_d;
  logic                out_fault_q, out_fault_d;
  logic                capture_s;
  logic                xfer_s;
  logic                last_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    quad_enc_channel #(
      .ENC_BITS    (ENC_BITS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk_i         (CLK),
      .rst_i         (reset),
      .enc_a_i       (ENC_A[i]),
      .enc_b_i       (ENC_B[i]),
      .mult_i        (multiplier[8*i +: 8]),
      .count_clear_i (count_clear[i]),
      .fault_clear_i (fault_clear[i]),
      .count_o       (live_count_s[i]),
      .fault_o       (live_fault_s[i])
    );
  end

  assign faultn      = ~live_fault_s;
  assign xfer_s      = valid_q && out_if.out_ready;
  assign last_s      = (chan_q == CH_W'(CHANNELS - 1));
  assign next_chan_s = chan_q + CH_W'(1'b1);

  // Snapshot FSM next-state and output decode
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    out_count_d = out_count_q;
    out_fault_d = out_fault_q;
    capture_s   = 1'b0;
    case (state_q)
      SNAP_IDLE: begin
        if (snap_req) begin
          capture_s   = 1'b1;
          state_d     = SNAP_STREAM;
          chan_d      = {CH_W{1'b0}};
          valid_d     = 1'b1;
          out_count_d = live_count_s[0];
          out_fault_d = live_fault_s[0];
        end else begin
          state_d = SNAP_IDLE;
        end
      end
      SNAP_STREAM: begin
        if (xfer_s && last_s) begin
          state_d = SNAP_IDLE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else if (xfer_s) begin
          chan_d      = next_chan_s;
          out_count_d = shadow_count_q[next_chan_s];
          out_fault_d = shadow_fault_q[next_chan_s];
        end else begin
          state_d = SNAP_STREAM;
        end
      end
      default: begin
        state_d = SNAP_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Snapshot FSM state, shadow copy and stream output registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q        <= SNAP_IDLE;
      chan_q         <= {CH_W{1'b0}};
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
      out_count_q    <= {ENC_BITS{1'b0}};
      out_fault_q    <= 1'b0;
      shadow_count_q <= '0;
      shadow_fault_q <= {CHANNELS{1'b0}};
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      out_count_q <= out_count_d;
      out_fault_q <= out_fault_d;
      if (capture_s) begin
        shadow_count_q <= live_count_s;
        shadow_fault_q <= live_fault_s;
      end else begin
        shadow_count_q <= shadow_count_q;
        shadow_fault_q <= shadow_fault_q;
      end
    end
  end

  assign snap_busy          = (state_q == SNAP_STREAM);
  assign snap_done          = done_q;
  assign out_if.out_valid   = valid_q;
  assign out_if.out_channel = chan_q;
  assign out_if.out_count   = out_count_q;
  assign out_if.out_fault   = out_fault_q;

endmodule

// File: tb/tb_quad_enc_bank.sv
// Directed bench: a 4-channel 32-bit bank plus a 1-channel 8-bit bank for wrap.
module tb_quad_enc_bank;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset = 1'b1;
  logic [3:0]  enc_a = 4'h0, enc_b = 4'h0;
  logic [31:0] mult = 32'h0;
  logic [3:0]  cclr = 4'h0, fclr = 4'h0;
  logic [3:0]  faultn;
  logic        snap_req = 1'b0, busy, done;

  logic [0:0]  enc8_a = 1'b0, enc8_b = 1'b0;
  logic [7:0]  mult8 = 8'd1;
  logic [0:0]  cclr8 = 1'b0, fclr8 = 1'b0, faultn8;
  logic        snap8 = 1'b0, busy8, done8;

  quad_enc_bank_if #(.CH_W(2), .ENC_BITS(32)) sif ();
  quad_enc_bank_if #(.CH_W(1), .ENC_BITS(8))  sif8 ();

  quad_enc_bank #(.CHANNELS(4), .ENC_BITS(32), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .reset(reset), .ENC_A(enc_a), .ENC_B(enc_b), .multiplier(mult),
    .count_clear(cclr), .fault_clear(fclr), .faultn(faultn), .snap_req(snap_req),
    .snap_busy(busy), .snap_done(done), .out_if(sif.master)
  );

  quad_enc_bank #(.CHANNELS(1), .ENC_BITS(8), .SYNC_STAGES(2)) dut8 (
    .CLK(CLK), .reset(reset), .ENC_A(enc8_a), .ENC_B(enc8_b), .multiplier(mult8),
    .count_clear(cclr8), .fault_clear(fclr8), .faultn(faultn8), .snap_req(snap8),
    .snap_busy(busy8), .snap_done(done8), .out_if(sif8.master)
  );

  int errors = 0;
  int checks = 0;
  logic [1:0] fwd_seq [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_ab(input int ch, input logic [1:0] ab);
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
  endtask

  task automatic beat(input string tag, input int ch, input logic [31:0] c, input logic f);
    check({tag, "_valid"}, 64'(sif.out_valid), 64'(1'b1));
    check({tag, "_chan"},  64'(sif.out_channel), 64'(ch));
    check({tag, "_count"}, {32'h0, sif.out_count}, {32'h0, c});
    check({tag, "_fault"}, 64'(sif.out_fault), 64'(f));
  endtask

  task automatic snap4(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3, input logic [3:0] ef);
    logic [31:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    sif.out_ready = 1'b1;
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("%s_b%0d", tag, i), i, ex[i], ef[i]);
      tick(1);
    end
    check({tag, "_done"},  64'(done), 64'(1'b1));
    check({tag, "_busy"},  64'(busy), 64'(1'b0));
    check({tag, "_vdrop"}, 64'(sif.out_valid), 64'(1'b0));
    tick(1);
    check({tag, "_done1"}, 64'(done), 64'(1'b0));
  endtask

  task automatic snap1(input string tag, input logic [7:0] ec);
    sif8.out_ready = 1'b1;
    snap8 = 1'b1;
    tick(1);
    snap8 = 1'b0;
    check({tag, "_valid"}, 64'(sif8.out_valid), 64'(1'b1));
    check({tag, "_chan"},  64'(sif8.out_channel), 64'(1'b0));
    check({tag, "_count"}, {56'h0, sif8.out_count}, {56'h0, ec});
    tick(1);
    check({tag, "_done"},  64'(done8), 64'(1'b1));
    check({tag, "_vdrop"}, 64'(sif8.out_valid), 64'(1'b0));
  endtask

  initial begin
    fwd_seq[0] = 2'b01; fwd_seq[1] = 2'b11; fwd_seq[2] = 2'b10; fwd_seq[3] = 2'b00;
    sif.out_ready  = 1'b0;
    sif8.out_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_valid", 64'(sif.out_valid), 64'(1'b0));
    check("rst_busy",  64'(busy), 64'(1'b0));
    check("rst_done",  64'(done), 64'(1'b0));
    check("rst_chan",  64'(sif.out_channel), 64'(2'd0));
    check("rst_count", {32'h0, sif.out_count}, 64'h0);
    check("rst_fault", 64'(sif.out_fault), 64'(1'b0));
    check("rst_faultn", 64'(faultn), 64'(4'hF));

    // ch0 forward x4 with multiplier 1
    mult = {8'd0, 8'd0, 8'd3, 8'd1};
    for (int i = 0; i < 4; i++) begin
      set_ab(0, fwd_seq[i]);
      tick(1);
    end
    tick(4);
    check("fwd_faultn", 64'(faultn), 64'(4'hF));
    snap4("fwd", 32'd4, 32'd0, 32'd0, 32'd0, 4'h0);

    // ch1 reverse x4 with multiplier 3
    set_ab(1, 2'b10); tick(1);
    set_ab(1, 2'b11); tick(1);
    set_ab(1, 2'b01); tick(1);
    set_ab(1, 2'b00); tick(4);
    snap4("rev", 32'd4, 32'hFFFF_FFF4, 32'd0, 32'd0, 4'h0);

    // count_clear lands on the same edge as a reverse step
    set_ab(1, 2'b10); tick(2);
    cclr[1] = 1'b1; tick(1);
    cclr[1] = 1'b0; tick(3);
    snap4("cclr", 32'd4, 32'd0, 32'd0, 32'd0, 4'h0);

    // ch2 illegal jump, then clear
    set_ab(2, 2'b11); tick(4);
    check("ill_faultn", 64'(faultn), 64'(4'b1011));
    snap4("ill", 32'd4, 32'd0, 32'd0, 32'd0, 4'b0100);
    fclr[2] = 1'b1; tick(1);
    fclr[2] = 1'b0; tick(1);
    check("fclr_faultn", 64'(faultn), 64'(4'hF));
    set_ab(2, 2'b00); tick(2);
    fclr[2] = 1'b1; tick(1);
    fclr[2] = 1'b0; tick(2);
    check("fclr_wins", 64'(faultn), 64'(4'hF));

    // ch3 multiplier 0: no count change, fault still detected
    set_ab(3, 2'b01); tick(1);
    set_ab(3, 2'b10); tick(4);
    check("m0_faultn", 64'(faultn), 64'(4'b0111));
    snap4("m0", 32'd4, 32'd0, 32'd0, 32'd0, 4'b1000);
    fclr[3] = 1'b1; tick(1);
    fclr[3] = 1'b0; tick(1);
    check("m0_fclr", 64'(faultn), 64'(4'hF));

    // 8-bit wrap on the single-channel bank
    for (int i = 0; i < 127; i++) begin
      enc8_a[0] = fwd_seq[i % 4][1];
      enc8_b[0] = fwd_seq[i % 4][0];
      tick(1);
    end
    tick(4);
    snap1("w127", 8'h7F);
    enc8_a[0] = 1'b0; enc8_b[0] = 1'b0; tick(4);
    snap1("wneg", 8'h80);
    enc8_a[0] = 1'b1; enc8_b[0] = 1'b0; tick(4);
    snap1("wback", 8'h7F);
    check("w_faultn", 64'(faultn8), 64'(1'b1));

    // counts {5,-2,0,9}, stream with back-pressure
    mult = {8'd9, 8'd0, 8'd1, 8'd1};
    set_ab(0, 2'b01); set_ab(1, 2'b11); set_ab(3, 2'b00); tick(1);
    set_ab(1, 2'b01); tick(4);
    snap_req = 1'b1; sif.out_ready = 1'b1; tick(1);
    snap_req = 1'b0;
    beat("s0", 0, 32'd5, 1'b0);
    set_ab(0, 2'b11);
    tick(1);
    beat("s1", 1, 32'hFFFF_FFFE, 1'b0);
    sif.out_ready = 1'b0; snap_req = 1'b1; tick(1);
    beat("s1hold", 1, 32'hFFFF_FFFE, 1'b0);
    check("s1hold_busy", 64'(busy), 64'(1'b1));
    sif.out_ready = 1'b1; snap_req = 1'b0; tick(1);
    beat("s2", 2, 32'd0, 1'b0);
    tick(1);
    beat("s3", 3, 32'd9, 1'b0);
    sif.out_ready = 1'b0; tick(1);
    beat("s3hold", 3, 32'd9, 1'b0);
    check("s3hold_done", 64'(done), 64'(1'b0));
    sif.out_ready = 1'b1; tick(1);
    check("s_done", 64'(done), 64'(1'b1));
    check("s_busy", 64'(busy), 64'(1'b0));
    check("s_vdrop", 64'(sif.out_valid), 64'(1'b0));
    tick(1);
    check("s_done1", 64'(done), 64'(1'b0));
    check("s_noreq", 64'(sif.out_valid), 64'(1'b0));
    snap4("live", 32'd6, 32'hFFFF_FFFE, 32'd0, 32'd9, 4'h0);

    // reset in the middle of the ch2 beat
    snap_req = 1'b1; sif.out_ready = 1'b1; tick(1);
    snap_req = 1'b0;
    set_ab(0, 2'b00); set_ab(1, 2'b00); set_ab(2, 2'b00); set_ab(3, 2'b00);
    beat("r0", 0, 32'd6, 1'b0);
    tick(1);
    beat("r1", 1, 32'hFFFF_FFFE, 1'b0);
    tick(1);
    beat("r2", 2, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    check("r_valid", 64'(sif.out_valid), 64'(1'b0));
    check("r_busy",  64'(busy), 64'(1'b0));
    tick(1);
    reset = 1'b0;
    tick(1);
    check("r_done",   64'(done), 64'(1'b0));
    check("r_faultn", 64'(faultn), 64'(4'hF));
    check("r_chan",   64'(sif.out_channel), 64'(2'd0));
    snap4("rz", 32'd0, 32'd0, 32'd0, 32'd0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
